writeback_unit: RTL and testbench
=================================

# writeback_unit

Final pipeline stage feeding the register file's single write port. Merges single-cycle ALU results and multi-cycle memory load completions into at most one register write per cycle, buffers ALU results when a load completion takes the port, and keeps a per-register scoreboard of outstanding loads so the decode stage can stall on hazards.

## Interface
- Parameters: `DEPTH`, 2, ALU result buffer entries (power of two, ≥2)
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `alu_valid` in 1: ALU result present this cycle
- `alu_ready` out 1: unit accepts the ALU result; transfer when `alu_valid && alu_ready`
- `alu_reg` in 3, `alu_data` in 16: destination register and value
- `mem_valid` in 1: load completion; always accepted, no ready
- `mem_reg` in 3, `mem_data` in 16: load destination and value
- `ld_issue` in 1, `ld_reg` in 3: load issued to memory; marks `ld_reg` busy
- `src_a_num`, `src_b_num`, `dst_num` in 3 each: decode-stage query registers
- `hazard` out 1: decode must stall
- `busy_mask` out 8: bit n set = load outstanding to rn
- `write_register_num` out 3, `write_register_in` out 16, `write_en` out 1: register file write port, registered

## Operation
- Priority at each edge, one winner: (1) `mem_valid` → output stage ← mem; (2) buffer non-empty → output stage ← buffer head, pop; (3) accepted ALU transfer with empty buffer → output stage ← ALU directly; (4) none → `write_en` ← 0.
- An accepted ALU result not taken by (3) is pushed to the buffer tail, same edge.
- `alu_ready` = buffer count < `DEPTH`, from registered count only (no combinational path from `mem_valid`).
- Push and pop on the same edge: count unchanged, FIFO order kept.
- Scoreboard: `ld_issue` sets `busy[ld_reg]`; `mem_valid` clears `busy[mem_reg]`; same register both events same edge → set wins. `ld_reg`/`mem_reg` = 0 never tracked; `busy_mask[0]` always 0.
- `hazard` (combinational) = busy bit of any nonzero `src_a_num`, `src_b_num`, `dst_num`.
- Writes to r0 pass through unchanged (register file drops data but updates condition bits).
- Load completions overtake buffered ALU results. `dst_num` hazard prevents WAW on registers; condition bits reflect write-port order, not program order — decode does not rely on them after a load until `busy_mask` clears.

## Timing
- Reset: buffer empty, `busy_mask` 0, `write_en` 0, `write_register_num` 0, `write_register_in` 0, `alu_ready` 1, `hazard` 0.
- ALU latency, no contention: accepted at edge N → `write_en` high in cycle after N.
- Load latency: `mem_valid` at edge N → write visible cycle after N; busy bit clear same edge.
- ALU result behind k buffered entries and m load completions: written after k+m+1 edges.
- Full buffer: `alu_ready` low until a pop edge; ALU must hold.
- Reset mid-operation: buffered results and busy bits discarded; upstream restarts.

## Configuration
- `WB_FORWARD_EN` defined: adds `fwd_a_in`, `fwd_b_in` (16, register file read values) and `fwd_a_out`, `fwd_b_out` (16). Out = youngest pending ALU value for that nonzero register (buffer tail first, then output stage), else input. `hazard` checks loads only.
- Undefined: no forwarding ports; `hazard` additionally asserts if any nonzero src/dst matches a valid buffer entry or the output stage while `write_en`.

## Structure
- Package `retro16_pkg`: `DATA_W`=16, `REG_NUM_W`=3, `NUM_REGS`=8, `PC_REG`=6, typedef `wb_entry_t` {reg num, data}.
- Sub-module `wb_result_fifo`: `DEPTH`-entry FIFO of `wb_entry_t` with push/pop/count plus per-entry valid/contents exposed for hazard and forwarding compare.

## Test plan
- Reset, then ALU r3=0x1234 → next cycle `write_en`=1, num 3, data 0x1234; `alu_ready` stays 1.
- ALU r1=0x0001, r2=0x0002, r4=0x0004 back-to-back, `mem_valid` r5=0xBEEF both first two cycles → writes r5,r5,r1,r2,r4 order; `alu_ready` low once buffer holds 2.
- `ld_issue` r2 → `busy_mask`=0x04, `src_a_num`=2 gives `hazard`=1; `mem_valid` r2 → mask 0, hazard 0.
- Same edge `ld_issue` r5 and `mem_valid` r5 → `busy_mask[5]` remains 1; `ld_issue` r0 → mask unchanged.
- Buffer full plus busy r3, assert `rst` mid-cycle → all outputs zero immediately, `alu_ready`=1, mask 0.
- With `WB_FORWARD_EN`: buffered r4=0x00AA, `src_a_num`=4, `fwd_a_in`=0x0000 → `fwd_a_out`=0x00AA, `hazard`=0; without macro same stimulus → `hazard`=1.

Source files
------------

// File: rtl/retro16_pkg.sv
// Shared widths and the write-back entry payload for the retro16 pipeline.
package retro16_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_NUM_W = 3;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned PC_REG    = 6;

    typedef struct packed {
        logic [REG_NUM_W-1:0] num;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of pending ALU results; every slot is exposed so the top can
// compare destinations for hazard detection and forwarding.
module wb_result_fifo
    import retro16_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  wb_entry_t             i_push_entry,
    input  logic                  i_pop,
    output logic [CNT_W-1:0]      o_count,
    output logic [PTR_W-1:0]      o_head,
    output logic [DEPTH-1:0]      o_valid,
    output wb_entry_t [DEPTH-1:0] o_entries
);

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    wb_entry_t [DEPTH-1:0] r_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mem   <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the count.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_valid
        assign o_valid[g] = {1'b0, PTR_W'(g) - r_head} < r_count;
    end

    assign o_count   = r_count;
    assign o_head    = r_head;
    assign o_entries = r_mem;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write arbiter: loads win the port, ALU results queue behind them,
// and a load scoreboard drives decode stalls. WB_FORWARD_EN adds operand forwarding.
module writeback_unit
    import retro16_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_NUM_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    input  logic [REG_NUM_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 ld_issue,
    input  logic [REG_NUM_W-1:0] ld_reg,
    input  logic [REG_NUM_W-1:0] src_a_num,
    input  logic [REG_NUM_W-1:0] src_b_num,
    input  logic [REG_NUM_W-1:0] dst_num,
`ifdef WB_FORWARD_EN
    input  logic [DATA_W-1:0]    fwd_a_in,
    input  logic [DATA_W-1:0]    fwd_b_in,
    output logic [DATA_W-1:0]    fwd_a_out,
    output logic [DATA_W-1:0]    fwd_b_out,
`endif
    output logic                 hazard,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic [REG_NUM_W-1:0] write_register_num,
    output logic [DATA_W-1:0]    write_register_in,
    output logic                 write_en
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  w_alu_fire;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count;
    logic [PTR_W-1:0]      w_head;
    logic [DEPTH-1:0]      w_valid;
    wb_entry_t [DEPTH-1:0] w_entries;
    wb_entry_t             w_head_entry;
    wb_entry_t             w_alu_entry;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic [REG_NUM_W-1:0]  w_q [3];

    logic [REG_NUM_W-1:0]  r_wnum;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_wen;
    logic [NUM_REGS-1:0]   r_busy;

    assign alu_ready    = w_count < CNT_W'(DEPTH);
    assign w_alu_fire   = alu_valid && alu_ready;
    assign w_empty      = (w_count == '0);
    assign w_alu_entry  = '{num: alu_reg, data: alu_data};
    assign w_head_entry = w_entries[w_head];
    // ALU goes straight to the port only when nothing else competes for it.
    assign w_push       = w_alu_fire && (mem_valid || !w_empty);
    assign w_pop        = !mem_valid && !w_empty;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_alu_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_valid      (w_valid),
        .o_entries    (w_entries)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_wnum  <= '0;
            r_wdata <= '0;
        end else if (mem_valid) begin
            r_wen   <= 1'b1;
            r_wnum  <= mem_reg;
            r_wdata <= mem_data;
        end else if (!w_empty) begin
            r_wen   <= 1'b1;
            r_wnum  <= w_head_entry.num;
            r_wdata <= w_head_entry.data;
        end else if (w_alu_fire) begin
            r_wen   <= 1'b1;
            r_wnum  <= alu_reg;
            r_wdata <= alu_data;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    // Load scoreboard: a new issue beats a same-edge completion; r0 never tracked.
    always_comb begin
        w_busy_nxt = r_busy;
        if (mem_valid && (mem_reg != '0)) w_busy_nxt[mem_reg] = 1'b0;
        if (ld_issue && (ld_reg != '0))   w_busy_nxt[ld_reg]  = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign w_q[0] = src_a_num;
    assign w_q[1] = src_b_num;
    assign w_q[2] = dst_num;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (w_q[k] != '0) begin
                if (r_busy[w_q[k]]) hazard = 1'b1;
`ifndef WB_FORWARD_EN
                if (r_wen && (r_wnum == w_q[k])) hazard = 1'b1;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (w_valid[i] && (w_entries[i].num == w_q[k])) hazard = 1'b1;
                end
`endif
            end
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] w_fwd_idx;

    // Walk oldest to youngest so the youngest matching value wins.
    always_comb begin
        fwd_a_out = fwd_a_in;
        fwd_b_out = fwd_b_in;
        w_fwd_idx = '0;
        if ((src_a_num != '0) && r_wen && (r_wnum == src_a_num)) fwd_a_out = r_wdata;
        if ((src_b_num != '0) && r_wen && (r_wnum == src_b_num)) fwd_b_out = r_wdata;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_fwd_idx = w_head + PTR_W'(i);
            if (w_valid[w_fwd_idx]) begin
                if ((src_a_num != '0) && (w_entries[w_fwd_idx].num == src_a_num))
                    fwd_a_out = w_entries[w_fwd_idx].data;
                if ((src_b_num != '0) && (w_entries[w_fwd_idx].num == src_b_num))
                    fwd_b_out = w_entries[w_fwd_idx].data;
            end
        end
    end
`endif

    assign busy_mask          = r_busy;
    assign write_en           = r_wen;
    assign write_register_num = r_wnum;
    assign write_register_in  = r_wdata;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized checks of writeback_unit against a queue-based model.
module tb_writeback_unit;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [2:0]  num;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [2:0]  mem_reg;
    logic [15:0] mem_data;
    logic        ld_issue;
    logic [2:0]  ld_reg;
    logic [2:0]  src_a_num, src_b_num, dst_num;
    logic        hazard;
    logic [7:0]  busy_mask;
    logic [2:0]  write_register_num;
    logic [15:0] write_register_in;
    logic        write_en;
`ifdef WB_FORWARD_EN
    logic [15:0] fwd_a_in, fwd_b_in, fwd_a_out, fwd_b_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    ent_t        q[$];
    logic [7:0]  m_busy;
    logic        m_en;
    logic [2:0]  m_num;
    logic [15:0] m_data;
    logic        m_acc;

    always #5 clk = ~clk;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_valid          (alu_valid),
        .alu_ready          (alu_ready),
        .alu_reg            (alu_reg),
        .alu_data           (alu_data),
        .mem_valid          (mem_valid),
        .mem_reg            (mem_reg),
        .mem_data           (mem_data),
        .ld_issue           (ld_issue),
        .ld_reg             (ld_reg),
        .src_a_num          (src_a_num),
        .src_b_num          (src_b_num),
        .dst_num            (dst_num),
`ifdef WB_FORWARD_EN
        .fwd_a_in           (fwd_a_in),
        .fwd_b_in           (fwd_b_in),
        .fwd_a_out          (fwd_a_out),
        .fwd_b_out          (fwd_b_out),
`endif
        .hazard             (hazard),
        .busy_mask          (busy_mask),
        .write_register_num (write_register_num),
        .write_register_in  (write_register_in),
        .write_en           (write_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard();
        logic       h;
        logic [2:0] qs [3];
        h = 1'b0;
        qs[0] = src_a_num;
        qs[1] = src_b_num;
        qs[2] = dst_num;
        foreach (qs[k]) begin
            if (qs[k] != 3'd0) begin
                if (m_busy[qs[k]]) h = 1'b1;
`ifndef WB_FORWARD_EN
                if (m_en && m_num == qs[k]) h = 1'b1;
                foreach (q[i]) if (q[i].num == qs[k]) h = 1'b1;
`endif
            end
        end
        return h;
    endfunction

`ifdef WB_FORWARD_EN
    function automatic logic [15:0] model_fwd(input logic [2:0] s, input logic [15:0] rf);
        logic [15:0] v;
        v = rf;
        if (s != 3'd0) begin
            if (m_en && m_num == s) v = m_data;
            foreach (q[i]) if (q[i].num == s) v = q[i].data;
        end
        return v;
    endfunction
`endif

    task automatic model_reset();
        q.delete();
        m_busy = 8'h00;
        m_en   = 1'b0;
        m_num  = 3'd0;
        m_data = 16'h0000;
        m_acc  = 1'b0;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_reg = 3'd0; mem_data = 16'h0;
        ld_issue  = 1'b0; ld_reg  = 3'd0;
        src_a_num = 3'd0; src_b_num = 3'd0; dst_num = 3'd0;
`ifdef WB_FORWARD_EN
        fwd_a_in = 16'h0; fwd_b_in = 16'h0;
`endif
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        ent_t e;
        #1;
        check("alu_ready", alu_ready, q.size() < DEPTH);
        check("hazard", hazard, model_hazard());
`ifdef WB_FORWARD_EN
        check("fwd_a_out", fwd_a_out, model_fwd(src_a_num, fwd_a_in));
        check("fwd_b_out", fwd_b_out, model_fwd(src_b_num, fwd_b_in));
`endif
        m_acc = alu_valid && (q.size() < DEPTH);
        if (m_acc) q.push_back('{num: alu_reg, data: alu_data});
        if (mem_valid) begin
            m_en = 1'b1; m_num = mem_reg; m_data = mem_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_en = 1'b1; m_num = e.num; m_data = e.data;
        end else begin
            m_en = 1'b0;
        end
        if (mem_valid && mem_reg != 3'd0) m_busy[mem_reg] = 1'b0;
        if (ld_issue && ld_reg != 3'd0)   m_busy[ld_reg]  = 1'b1;
        @(posedge clk);
        #1;
        check("write_en", write_en, m_en);
        check("write_num", write_register_num, m_num);
        check("write_data", write_register_in, m_data);
        check("busy_mask", busy_mask, m_busy);
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_write_en", write_en, 1'b0);
        check("rst_num", write_register_num, 3'd0);
        check("rst_data", write_register_in, 16'h0);
        check("rst_busy", busy_mask, 8'h00);
        check("rst_ready", alu_ready, 1'b1);
        check("rst_hazard", hazard, 1'b0);
        rst = 1'b0;

        // Uncontended ALU result
        alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 16'h1234;
        cycle();
        idle();
        check("alu_direct_en", write_en, 1'b1);
        check("alu_direct_data", write_register_in, 16'h1234);
        #1 check("alu_ready_stays", alu_ready, 1'b1);
        cycle();

        // Loads overtake buffered ALU results
        alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_reg = 3'd5; mem_data = 16'hBEEF;
        cycle();
        alu_reg = 3'd2; alu_data = 16'h0002;
        cycle();
        check("order_w1", write_register_num, 3'd5);
        alu_reg = 3'd4; alu_data = 16'h0004;
        mem_valid = 1'b0;
        #1 check("full_ready_low", alu_ready, 1'b0);
        cycle();
        check("order_w3", write_register_num, 3'd1);
        cycle();
        check("order_w4", write_register_num, 3'd2);
        idle();
        cycle();
        check("order_w5", write_register_num, 3'd4);
        check("order_w5_data", write_register_in, 16'h0004);
        cycle();

        // Scoreboard set/clear
        ld_issue = 1'b1; ld_reg = 3'd2;
        cycle();
        check("ld_mask", busy_mask, 8'h04);
        idle();
        src_a_num = 3'd2;
        #1 check("ld_hazard", hazard, 1'b1);
        mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 16'h5555;
        cycle();
        check("clr_mask", busy_mask, 8'h00);
        mem_valid = 1'b0;
        cycle();
        check("clr_hazard", hazard, 1'b0);
        idle();

        // Same-edge set and clear, and r0 never tracked
        ld_issue = 1'b1; ld_reg = 3'd5;
        mem_valid = 1'b1; mem_reg = 3'd5; mem_data = 16'h7777;
        cycle();
        check("set_wins", busy_mask, 8'h20);
        idle();
        ld_issue = 1'b1; ld_reg = 3'd0;
        cycle();
        check("r0_untracked", busy_mask, 8'h20);
        idle();

        // Fill the buffer with r3 busy, then reset mid-cycle
        ld_issue = 1'b1; ld_reg = 3'd3;
        cycle();
        idle();
        mem_valid = 1'b1; mem_reg = 3'd6; mem_data = 16'h6666;
        alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 16'h1111;
        cycle();
        alu_reg = 3'd2; alu_data = 16'h2222;
        cycle();
        idle();
        src_a_num = 3'd3;
        #1 check("pre_rst_ready", alu_ready, 1'b0);
        check("pre_rst_hazard", hazard, 1'b1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_en", write_en, 1'b0);
        check("mid_rst_num", write_register_num, 3'd0);
        check("mid_rst_data", write_register_in, 16'h0);
        check("mid_rst_busy", busy_mask, 8'h00);
        check("mid_rst_ready", alu_ready, 1'b1);
        check("mid_rst_hazard", hazard, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Buffered ALU value against a matching source operand
        mem_valid = 1'b1; mem_reg = 3'd6; mem_data = 16'h0606;
        alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 16'h00AA;
        cycle();
        idle();
        src_a_num = 3'd4;
        #1;
`ifdef WB_FORWARD_EN
        check("fwd_buffered", fwd_a_out, 16'h00AA);
        check("fwd_no_hazard", hazard, 1'b0);
`else
        check("buffered_hazard", hazard, 1'b1);
`endif
        cycle();
        idle();
        cycle();

        // Randomized traffic; a stalled ALU request holds its values
        for (int n = 0; n < 400; n++) begin
            if (!(alu_valid && !m_acc)) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_reg   = 3'($urandom);
                alu_data  = 16'($urandom);
            end
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_reg   = 3'($urandom);
            mem_data  = 16'($urandom);
            ld_issue  = ($urandom_range(0, 3) == 0);
            ld_reg    = 3'($urandom);
            src_a_num = 3'($urandom);
            src_b_num = 3'($urandom);
            dst_num   = 3'($urandom);
`ifdef WB_FORWARD_EN
            fwd_a_in  = 16'($urandom);
            fwd_b_in  = 16'($urandom);
`endif
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
